ula_multiciclo: RTL and testbench

Parametrised multicycle ALU for the datapath. Keeps the existing Control_ALU opcode map and adds signed compare, arithmetic shift, carry/overflow/negative flags, and a Start/Busy/Done handshake. Multiply and divide are iterative and take WIDTH cycles; all other operations complete in one registered cycle. Sits between the register-file read stage and write-back; the control unit stalls on Busy.

---
 rtl/ula_multiciclo.sv | 148 ++++++++++++++
 tb/tb_ula_multiciclo.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/ula_multiciclo.sv
// ula_multiciclo: multicycle ALU with single-cycle logic/arith/shift ops and
// iterative shift-add MUL / restoring DIV behind a Start/Busy/Done handshake.
module ula_multiciclo #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic [3:0]         Control_ALU,
    input  logic [WIDTH-1:0]   Input_1,
    input  logic [WIDTH-1:0]   Input_2,
    input  logic [SHAMT_W-1:0] Shamt,
    output logic               Busy,
    output logic               Done,
    output logic [WIDTH-1:0]   Output_Resultado,
    output logic [WIDTH-1:0]   Output_Alto,
    output logic               Zero,
    output logic               Negativo,
    output logic               Carry,
    output logic               Overflow,
    output logic               Div_Zero
);
    typedef enum logic {IDLE, CALC} state_t;
    state_t state, state_next;
    logic [SHAMT_W-1:0] cnt;
    logic               is_mul;
    logic [WIDTH-1:0]   op_b, hi, lo, hi_n, lo_n, res, alto;
    logic [WIDTH:0]     sum, shifted, add_r;
    logic [WIDTH-1:0]   sub_r;
    logic               ge, carry, ovf, dz, iter_op, last, commit;

    assign iter_op  = Control_ALU == 4'b1000 || (Control_ALU == 4'b1001 && Input_2 != '0);
    assign last     = state == CALC && &cnt;
    assign commit   = (state == IDLE && Start && !iter_op) || last;
    assign Busy     = state == CALC;
    assign Negativo = Output_Resultado[WIDTH-1];
    assign add_r    = {1'b0, Input_1} + {1'b0, Input_2};
    assign sub_r    = Input_1 - Input_2;

    // hi:lo holds product (MUL) or remainder:quotient (DIV) while iterating
    always_comb begin
        sum     = {1'b0, hi} + {1'b0, op_b};
        shifted = {hi, lo[WIDTH-1]};
        ge      = shifted >= {1'b0, op_b};
        hi_n    = hi;
        lo_n    = lo;
        if (is_mul)
            {hi_n, lo_n} = lo[0] ? {sum, lo[WIDTH-1:1]} : {1'b0, hi, lo[WIDTH-1:1]};
        else begin
            hi_n = ge ? shifted[WIDTH-1:0] - op_b : shifted[WIDTH-1:0];
            lo_n = {lo[WIDTH-2:0], ge};
        end
    end

    always_comb begin
        res   = '0;
        alto  = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        dz    = 1'b0;
        if (state == CALC) begin
            res  = lo_n;
            alto = hi_n;
            ovf  = is_mul && hi_n != '0;
        end else begin
            case (Control_ALU)
                4'b0000: res = Input_1 & Input_2;
                4'b0001: res = Input_1 | Input_2;
                4'b0010: begin
                    res   = add_r[WIDTH-1:0];
                    carry = add_r[WIDTH];
                    ovf   = Input_1[WIDTH-1] == Input_2[WIDTH-1] && res[WIDTH-1] != Input_1[WIDTH-1];
                end
                4'b0110: begin
                    res   = sub_r;
                    carry = Input_1 < Input_2;
                    ovf   = Input_1[WIDTH-1] != Input_2[WIDTH-1] && res[WIDTH-1] != Input_1[WIDTH-1];
                end
                4'b0011: res = Input_1 ^ Input_2;
                4'b0111: res = {{(WIDTH-1){1'b0}}, $signed(Input_1) < $signed(Input_2)};
                4'b0100: res = {{(WIDTH-1){1'b0}}, Input_1 < Input_2};
                4'b1001: begin
                    res  = '1;
                    alto = Input_1;
                    dz   = 1'b1;
                end
                4'b1100: res = ~(Input_1 | Input_2);
                4'b1101: res = Input_1 >> Shamt;
                4'b1110: res = $signed(Input_1) >>> Shamt;
                4'b1111: res = Input_1 << Shamt;
                default: res = '0;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        if (state == IDLE && Start && iter_op)
            state_next = CALC;
        else if (last)
            state_next = IDLE;
    end

    always_ff @(posedge Clock)
        if (!Reset)
            state <= IDLE;
        else
            state <= state_next;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            cnt              <= '0;
            is_mul           <= 1'b0;
            op_b             <= '0;
            hi               <= '0;
            lo               <= '0;
            Done             <= 1'b0;
            Output_Resultado <= '0;
            Output_Alto      <= '0;
            Zero             <= 1'b0;
            Carry            <= 1'b0;
            Overflow         <= 1'b0;
            Div_Zero         <= 1'b0;
        end else begin
            Done <= commit;
            if (state == IDLE && Start && iter_op) begin
                cnt    <= '0;
                is_mul <= Control_ALU == 4'b1000;
                op_b   <= Input_2;
                hi     <= '0;
                lo     <= Input_1;
            end else if (state == CALC) begin
                cnt <= cnt + 1'b1;
                hi  <= hi_n;
                lo  <= lo_n;
            end
            if (commit) begin
                Output_Resultado <= res;
                Output_Alto      <= alto;
                Zero             <= res == '0;
                Carry            <= carry;
                Overflow         <= ovf;
                Div_Zero         <= dz;
            end
        end
    end
endmodule

// File: tb/tb_ula_multiciclo.sv
// tb_ula_multiciclo: directed and random operations checked against an
// arithmetic reference model of the ALU.
module tb_ula_multiciclo;
    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [3:0]  Control_ALU = '0;
    logic [31:0] Input_1 = '0, Input_2 = '0;
    logic [4:0]  Shamt = '0;
    logic        Busy, Done, Zero, Negativo, Carry, Overflow, Div_Zero;
    logic [31:0] Output_Resultado, Output_Alto;
    int          n_cmp = 0, n_err = 0;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] alto;
        logic        c, v, dz, iter;
    } exp_t;

    ula_multiciclo dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Control_ALU(Control_ALU),
        .Input_1(Input_1), .Input_2(Input_2), .Shamt(Shamt), .Busy(Busy), .Done(Done),
        .Output_Resultado(Output_Resultado), .Output_Alto(Output_Alto), .Zero(Zero),
        .Negativo(Negativo), .Carry(Carry), .Overflow(Overflow), .Div_Zero(Div_Zero)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        exp_t        e;
        longint      sa, sb, s;
        logic [63:0] w;
        e  = '0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0010: begin
                w = {32'b0, a} + {32'b0, b};
                e.res = w[31:0];
                e.c = w[32];
                s = sa + sb;
                e.v = s > 64'sd2147483647 || s < -64'sd2147483648;
            end
            4'b0110: begin
                e.res = a - b;
                e.c = a < b;
                s = sa - sb;
                e.v = s > 64'sd2147483647 || s < -64'sd2147483648;
            end
            4'b0011: e.res = a ^ b;
            4'b0111: e.res = {31'b0, sa < sb};
            4'b0100: e.res = {31'b0, a < b};
            4'b1000: begin
                w = {32'b0, a} * {32'b0, b};
                e.res = w[31:0];
                e.alto = w[63:32];
                e.v = e.alto != 0;
                e.iter = 1'b1;
            end
            4'b1001: begin
                if (b == 0) begin
                    e.res = 32'hFFFF_FFFF;
                    e.alto = a;
                    e.dz = 1'b1;
                end else begin
                    e.res = a / b;
                    e.alto = a % b;
                    e.iter = 1'b1;
                end
            end
            4'b1100: e.res = ~(a | b);
            4'b1101: e.res = a >> sh;
            4'b1110: begin
                s = sa >>> sh;
                e.res = s[31:0];
            end
            4'b1111: e.res = a << sh;
            default: e.res = '0;
        endcase
        return e;
    endfunction

    // Issues one operation and waits (bounded) for Done; optionally pokes a
    // second Start with fresh operands while the first is still busy.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh, input bit poke);
        exp_t e;
        int   n, busy;
        e = model(op, a, b, sh);
        Control_ALU = op;
        Input_1 = a;
        Input_2 = b;
        Shamt = sh;
        Start = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        n = 0;
        busy = 0;
        while (!Done && n < 100) begin
            if (Busy) busy++;
            Start = poke && n == 5;
            if (Start) begin
                Control_ALU = 4'b0010;
                Input_1 = $urandom;
                Input_2 = $urandom;
            end
            @(posedge Clock);
            #1;
            n++;
        end
        Start = 1'b0;
        check($sformatf("done_seen op%b", op), {63'b0, Done}, 64'd1);
        check($sformatf("busy_cycles op%b", op), busy, e.iter ? 32 : 0);
        check($sformatf("res op%b a=%h b=%h", op, a, b), Output_Resultado, e.res);
        check($sformatf("alto op%b", op), Output_Alto, e.alto);
        check($sformatf("flags zncvd op%b", op), {Zero, Negativo, Carry, Overflow, Div_Zero},
              {e.res == 0, e.res[31], e.c, e.v, e.dz});
        @(posedge Clock);
        #1;
        check("done_pulse", {63'b0, Done}, 64'd0);
        check("hold_res", Output_Resultado, e.res);
    endtask

    initial begin
        Start = 1'b1;
        Control_ALU = 4'b0010;
        Input_1 = 32'd1;
        Input_2 = 32'd1;
        repeat (2) @(posedge Clock);
        #1;
        check("rst_outputs", {Output_Resultado, Output_Alto}, 64'd0);
        check("rst_flags bdzncvd", {Busy, Done, Zero, Negativo, Carry, Overflow, Div_Zero}, 64'd0);
        Start = 1'b0;
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        check("idle_after_rst", {Busy, Done}, 64'd0);

        run_op(4'b0010, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b0);
        run_op(4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
        run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
        run_op(4'b0100, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
        run_op(4'b1110, 32'h8000_0000, 32'd0, 5'd4, 1'b0);
        run_op(4'b1101, 32'h8000_0000, 32'd0, 5'd4, 1'b0);
        run_op(4'b0110, 32'd3, 32'd5, 5'd0, 1'b0);
        run_op(4'b0110, 32'h8000_0000, 32'd1, 5'd0, 1'b0);
        run_op(4'b1000, 32'hFFFF_FFFF, 32'd2, 5'd0, 1'b1);
        run_op(4'b1001, 32'd100, 32'd7, 5'd0, 1'b1);
        run_op(4'b1001, 32'd5, 32'd0, 5'd0, 1'b0);
        run_op(4'b1010, 32'd9, 32'd9, 5'd0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'($urandom_range(0, 15));
            a = $urandom;
            b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
            run_op(op, a, b, 5'($urandom), 1'($urandom));
        end

        Control_ALU = 4'b1001;
        Input_1 = 32'd100;
        Input_2 = 32'd7;
        Start = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        repeat (9) @(posedge Clock);
        #1;
        check("abort_busy_before", {63'b0, Busy}, 64'd1);
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        Reset = 1'b1;
        check("abort_outputs", {Output_Resultado, Output_Alto}, 64'd0);
        check("abort_flags bdzncvd", {Busy, Done, Zero, Negativo, Carry, Overflow, Div_Zero}, 64'd0);
        for (int i = 0; i < 40; i++) begin
            @(posedge Clock);
            #1;
            if (Done) check("abort_no_done", {63'b0, Done}, 64'd0);
        end
        check("abort_stays_idle", {Busy, Done}, 64'd0);
        run_op(4'b0010, 32'd3, 32'd4, 5'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
